seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised serial pattern detector for single-bit streams. It replaces fixed hard-coded detectors such as the 4-bit "1001" Mealy detector. The detected pattern, its length and the overlap mode are all configurable, and an input qualifier lets the stream stall without losing state. It sits directly on a serial data path and produces a one-cycle registered match pulse plus an optional match counter for status logic.

## Interface
- PAT_LEN, 4: pattern length in bits; legal range 2..32.
- PATTERN, 4'b1001: pattern to detect, PAT_LEN bits wide; MSB is the first bit received.
- CNT_W, 8: width of the match counter; legal range 1..32.

- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of history, fill count, dout, counter and cnt_sat.
- overlap  input  1  mode select: 1 = overlapping detection, 0 = non-overlapping.
- din_valid  input  1  qualifies din; din is ignored when low.
- din  input  1  serial data bit.
- dout  output  1  registered match pulse.
- match_cnt  output  CNT_W  saturating count of matches.
- cnt_sat  output  1  high while match_cnt is at its maximum value.

## Operation
- State:
  - history shift register hist[PAT_LEN-1:0].
  - fill counter fill, range 0..PAT_LEN, counts valid bits since the last restart.
- Accepted bit (din_valid=1, clear=0):
  - hist_n = {hist[PAT_LEN-2:0], din}.
  - fill_n = min(fill+1, PAT_LEN).
- Match condition: fill_n == PAT_LEN and hist_n == PATTERN.
- On match:
  - dout <= 1.
  - match_cnt increments unless already at 2^CNT_W-1.
  - overlap=1: fill stays at PAT_LEN, so a pattern suffix can start the next match.
  - overlap=0: fill <= 0 and hist <= 0; the next match needs PAT_LEN fresh bits.
- Any cycle without a match, including din_valid=0: dout <= 0.
- With din_valid=0, hist, fill and match_cnt hold.
- overlap is sampled only on cycles that produce a match, so a mode change applies from the next match decision.
- clear=1 has priority over din_valid:
  - hist, fill, dout, match_cnt and cnt_sat go to 0.
  - The bit presented in that cycle is discarded.
- cnt_sat = (match_cnt == 2^CNT_W-1); derived combinationally from the counter register.

## Timing
- Reset values: dout=0, match_cnt=0, cnt_sat=0, hist=0, fill=0.
- Latency:
  - dout rises on the same clock edge that samples the final pattern bit, and stays high exactly one cycle per match.
  - In overlapping mode a back-to-back match may keep dout high across consecutive cycles, e.g. PATTERN=2'b11 with a run of 1s.
- match_cnt updates on the same edge as dout rises.
- Reset mid-pattern discards partial history; no match can complete from pre-reset bits.
- clear arriving together with a completing bit: no pulse and no count.
- Saturated counter: further matches still pulse dout; match_cnt stays at maximum.

## Configuration
- SEQ_DET_CNT_EN defined: the match counter and saturation logic are built as described.
- SEQ_DET_CNT_EN undefined:
  - match_cnt and cnt_sat are tied to 0, with no counter flops.
  - dout behaviour is unchanged.

## Structure
- Package seq_det_pkg holds:
  - default PATTERN and PAT_LEN constants.
  - the overlap-mode encoding constants MODE_NONOVL=0 and MODE_OVL=1.
  - the PAT_LEN and CNT_W legal-range limits, used for elaboration checks.
- One sub-module, seq_det_sat_counter: a CNT_W-bit saturating counter with synchronous clear, increment enable and a sat flag. It is instantiated only under SEQ_DET_CNT_EN.

## Test plan
- Overlapping default: overlap=1, valid bits 1,0,0,1,0,0,1 -> dout pulses after bits 4 and 7; match_cnt=2.
- Non-overlapping default: overlap=0, same stream -> one pulse after bit 4; match_cnt=1; the trailing 0,0,1 does not match.
- Stalls: bits 1,0, then din_valid=0 for 3 cycles with din toggling, then bits 0,1 -> single pulse on the edge sampling the final 1; dout=0 throughout the stall.
- Reset mid-pattern: bits 1,0,0, assert reset one cycle, then bit 1 -> no pulse; all outputs 0 after reset.
- Saturation, CNT_W=2, overlap=1: stream 1,0,0,1,0,0,1,0,0,1,0,0,1,0,0,1 gives 5 matches -> match_cnt reads 3 and cnt_sat=1 from the 3rd match onward; dout still pulses on matches 4 and 5.
- Clear collision: bits 1,0,0, then bit 1 presented together with clear=1 -> no pulse; match_cnt=0. The following bits 1,0,0,1 give a pulse after the 4th bit.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants for the serial pattern detector.
//   - default pattern / length used when the top is not overridden
//   - overlap-mode encoding seen on the overlap input
//   - legal parameter ranges checked at elaboration
package seq_det_pkg;

  localparam int         DEF_PAT_LEN = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1001;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 32;
  localparam int CNT_W_MIN   = 1;
  localparam int CNT_W_MAX   = 32;

endpackage

// File: rtl/seq_det_sat_counter.sv
// seq_det_sat_counter: CNT_W-bit saturating up-counter.
//   i_clk    clock
//   i_rst    async active-high reset
//   i_clear  sync clear (priority over i_inc)
//   i_inc    increment request, ignored once saturated
//   o_cnt    counter value
//   o_sat    high while o_cnt is all ones
module seq_det_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat
);

  logic [CNT_W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_sat = &r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                r_cnt <= '0;
    else if (i_clear)         r_cnt <= '0;
    else if (i_inc && !o_sat) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial pattern detector.
//   clk        clock
//   reset      async active-high reset
//   clear      sync clear of history, fill, dout and counter
//   overlap    1 = overlapping, 0 = non-overlapping detection
//   din_valid  qualifies din
//   din        serial bit, first pattern bit = PATTERN MSB
//   dout       registered one-cycle match pulse
//   match_cnt  saturating match count (0 unless SEQ_DET_CNT_EN)
//   cnt_sat    match_cnt at maximum (0 unless SEQ_DET_CNT_EN)
// Build option: define SEQ_DET_CNT_EN to build the match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             overlap,
  input  logic             din_valid,
  input  logic             din,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_pat_len
    $error("seq_detector_param: PAT_LEN out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W out of range");
  end

  localparam int FW = $clog2(PAT_LEN + 1);

  logic [PAT_LEN-1:0] r_hist;
  logic [FW-1:0]      r_fill;
  logic               r_dout;

  logic [PAT_LEN-1:0] w_hist_n;
  logic [FW-1:0]      w_fill_n;
  logic               w_match;

  assign w_hist_n = {r_hist[PAT_LEN-2:0], din};
  // fill saturates at PAT_LEN: it only gates the first match after a restart
  assign w_fill_n = (r_fill == FW'(PAT_LEN)) ? r_fill : r_fill + 1'b1;
  assign w_match  = din_valid && !clear &&
                    (w_fill_n == FW'(PAT_LEN)) && (w_hist_n == PATTERN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
      r_dout <= 1'b0;
    end else if (clear) begin
      r_hist <= '0;
      r_fill <= '0;
      r_dout <= 1'b0;
    end else if (din_valid) begin
      r_dout <= w_match;
      // non-overlapping: a match consumes its bits, restart collection
      if (w_match && overlap == MODE_NONOVL) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_hist_n;
        r_fill <= w_fill_n;
      end
    end else begin
      r_dout <= 1'b0;
    end
  end

  assign dout = r_dout;

`ifdef SEQ_DET_CNT_EN
  seq_det_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_clear (clear),
    .i_inc   (w_match),
    .o_cnt   (match_cnt),
    .o_sat   (cnt_sat)
  );
`else
  assign match_cnt = '0;
  assign cnt_sat   = 1'b0;
`endif

endmodule
